// File: rtl/conv_mem_arbiter.sv
// rtl/conv_mem_arbiter.sv - burst-atomic round-robin arbiter for the shared conv data memory
// Three requesters (filter, slice, write-back) post bursts; the owner keeps the port until done.
module conv_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            wr,
  input  logic [3*ADDR_W-1:0]   base,
  input  logic [3*LEN_W-1:0]    len,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            beat_ack,
  output logic [2:0]            done,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_adr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_TAIL} state_t;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   cur_adr_q, cur_adr_d;
  logic [LEN_W-1:0]    beats_left_q, beats_left_d;
  logic                dir_q, dir_d;
  logic                rvalid_q, rvalid_d;
  logic                null_done_q, null_done_d;

  // Per-requester views, padded to four entries so a 2-bit index never leaves the array.
  logic [ADDR_W-1:0]   base_a  [4];
  logic [LEN_W-1:0]    len_a   [4];
  logic [DATA_W-1:0]   wdata_a [4];
  logic [3:0]          req4, wr4;

  logic [1:0]          cand1, cand2, cand3, winner;
  logic [2:0]          owner_oh;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      base_a[i]  = base[i*ADDR_W +: ADDR_W];
      len_a[i]   = len[i*LEN_W +: LEN_W];
      wdata_a[i] = wdata[i*DATA_W +: DATA_W];
    end
    base_a[3]  = '0;
    len_a[3]   = '0;
    wdata_a[3] = '0;
    req4       = {1'b0, req};
    wr4        = {1'b0, wr};
  end

  // Round-robin search starts just after the previous winner.
  always_comb begin
    cand1 = next_idx(last_owner_q);
    cand2 = next_idx(cand1);
    cand3 = next_idx(cand2);
    if (req4[cand1])      winner = cand1;
    else if (req4[cand2]) winner = cand2;
    else                  winner = cand3;
  end

  assign owner_oh = 3'b001 << owner_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cur_adr_d    = cur_adr_q;
    beats_left_d = beats_left_q;
    dir_d        = dir_q;
    null_done_d  = 1'b0;
    rvalid_d     = (state_q == S_BURST) && !dir_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d      = winner;
          last_owner_d = winner;
          cur_adr_d    = base_a[winner];
          beats_left_d = len_a[winner];
          dir_d        = wr4[winner];
          if (len_a[winner] == '0) null_done_d = 1'b1;
          else                     state_d     = S_BURST;
        end
      end
      S_BURST: begin
        cur_adr_d    = cur_adr_q + ADDR_W'(1);
        beats_left_d = beats_left_q - LEN_W'(1);
        // Reads need one more cycle for the last beat's data to come back.
        if (beats_left_q == LEN_W'(1)) state_d = dir_q ? S_IDLE : S_TAIL;
      end
      S_TAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd2;
      cur_adr_q    <= '0;
      beats_left_q <= '0;
      dir_q        <= 1'b0;
      rvalid_q     <= 1'b0;
      null_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cur_adr_q    <= cur_adr_d;
      beats_left_q <= beats_left_d;
      dir_q        <= dir_d;
      rvalid_q     <= rvalid_d;
      null_done_q  <= null_done_d;
    end
  end

  always_comb begin
    gnt       = '0;
    beat_ack  = '0;
    done      = '0;
    rvalid    = '0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    case (state_q)
      S_BURST: begin
        gnt      = owner_oh;
        beat_ack = owner_oh;
        mem_en   = 1'b1;
        mem_wr   = dir_q;
        mem_adr  = cur_adr_q;
        if (dir_q) mem_wdata = wdata_a[owner_q];
        if (beats_left_q == LEN_W'(1)) done = owner_oh;
      end
      S_TAIL:  gnt = owner_oh;
      default: ;
    endcase
    if (null_done_q) done = owner_oh;
    if (rvalid_q) begin
      rvalid = owner_oh;
      rdata  = mem_rdata;
    end
  end

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// tb/tb_conv_mem_arbiter.sv - self-checking bench for conv_mem_arbiter
// Scoreboard queues hold expected beats, read returns and done pulses with their cycle numbers.
module tb_conv_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2:0]        req = '0;
  logic [2:0]        wr = '0;
  logic [3*AW-1:0]   base = '0;
  logic [3*LW-1:0]   len = '0;
  logic [3*DW-1:0]   wdata;
  logic [2:0]        gnt, beat_ack, done, rvalid;
  logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_wr;
  logic [AW-1:0]     mem_adr;

  conv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .base(base), .len(len), .wdata(wdata),
    .gnt(gnt), .beat_ack(beat_ack), .done(done), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [7:0] a);
    case (a)
      8'h00:   return 8'h11;
      8'h01:   return 8'h22;
      8'h02:   return 8'h33;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] seed(input int o);
    case (o)
      0:       return 8'hA0;
      1:       return 8'h40;
      default: return 8'hC0;
    endcase
  endfunction

  // Requester write-data sources step on every beat_ack they receive.
  logic [7:0] wcnt [3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst)             wcnt[i] <= 8'h00;
      else if (beat_ack[i]) wcnt[i] <= wcnt[i] + 8'h01;
    end
  end
  assign wdata = {8'hC0 + wcnt[2], 8'h40 + wcnt[1], 8'hA0 + wcnt[0]};

  // Memory model, 256 entries aliased on the low address byte.
  logic [7:0] mem [256];
  bit loaded;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int a = 0; a < 256; a++) mem[a] <= pat(8'(a));
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_wr) mem[mem_adr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_adr[7:0]];
    end
  end

  typedef struct { int cyc; int owner; logic w; logic [15:0] adr; logic [7:0] data; } beat_t;
  typedef struct { int cyc; int owner; logic [7:0] data; } ev_t;
  typedef struct { int o; logic w; logic [15:0] b; int l; logic [15:0] end_adr; } vec_t;

  beat_t beat_q[$];
  ev_t   rd_q[$];
  ev_t   done_q[$];
  logic [7:0] golden [256];
  int    issued [3];
  int    total = 0;
  int    bad = 0;
  logic [15:0] last_done_adr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pushes the expected trace of one burst and returns the IDLE cycle in which the next grant is decided.
  function automatic int push_burst(input int o, input logic w, input logic [15:0] b,
                                    input int l, input int start, input int cut);
    int n;
    logic [15:0] a;
    beat_t bt;
    ev_t e;
    n = (l < cut) ? l : cut;
    a = b;
    if (l == 0) begin
      e.cyc = start + 1; e.owner = o; e.data = 8'h00;
      done_q.push_back(e);
      return start + 1;
    end
    for (int k = 0; k < n; k++) begin
      bt.cyc = start + 1 + k; bt.owner = o; bt.w = w; bt.adr = a;
      if (w) begin
        bt.data = seed(o) + 8'(issued[o]);
        golden[a[7:0]] = bt.data;
      end else begin
        bt.data = 8'h00;
        e.cyc = start + 2 + k; e.owner = o; e.data = golden[a[7:0]];
        rd_q.push_back(e);
      end
      issued[o]++;
      beat_q.push_back(bt);
      a = a + 16'd1;
    end
    if (n == l) begin
      e.cyc = start + l; e.owner = o; e.data = 8'h00;
      done_q.push_back(e);
    end
    return w ? start + l + 1 : start + l + 2;
  endfunction

  always @(negedge clk) begin
    if (rst && loaded) begin
      check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      if (beat_q.size() != 0 && beat_q[0].cyc == cyc) check("beat_due", 64'(mem_en), 64'd1);
      if (rd_q.size() != 0 && rd_q[0].cyc == cyc)     check("rvalid_due", 64'(|rvalid), 64'd1);
      if (done_q.size() != 0 && done_q[0].cyc == cyc) check("done_due", 64'(|done), 64'd1);
      if (mem_en) begin
        check("beat_pending", 64'(beat_q.size() != 0), 64'd1);
        if (beat_q.size() != 0) begin
          beat_t bt;
          bt = beat_q.pop_front();
          check("beat_cycle", 64'(cyc), 64'(bt.cyc));
          check("beat_gnt", 64'(gnt), 64'(3'b001 << bt.owner));
          check("beat_ack", 64'(beat_ack), 64'(3'b001 << bt.owner));
          check("beat_wr", 64'(mem_wr), 64'(bt.w));
          check("beat_adr", 64'(mem_adr), 64'(bt.adr));
          check("beat_wdata", 64'(mem_wdata), 64'(bt.data));
        end
      end else if (rvalid == 3'b000) begin
        check("gnt_idle", 64'(gnt), 64'd0);
      end
      if (|rvalid) begin
        check("rd_pending", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) begin
          ev_t e;
          e = rd_q.pop_front();
          check("rd_cycle", 64'(cyc), 64'(e.cyc));
          check("rd_owner", 64'(rvalid), 64'(3'b001 << e.owner));
          check("rd_data", 64'(rdata), 64'(e.data));
          if (!mem_en) check("gnt_tail", 64'(gnt), 64'(3'b001 << e.owner));
        end
      end
      if (|done) begin
        check("done_pending", 64'(done_q.size() != 0), 64'd1);
        if (mem_en) last_done_adr = mem_adr;
        if (done_q.size() != 0) begin
          ev_t e;
          e = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("done_owner", 64'(done), 64'(3'b001 << e.owner));
        end
      end
    end
  end

  task automatic set_req(input int o, input logic w, input logic [15:0] b, input int l);
    wr[o] = w;
    base[o*AW +: AW] = b;
    len[o*LW +: LW] = LW'(l);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((beat_q.size() + rd_q.size() + done_q.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(beat_q.size() + rd_q.size() + done_q.size()), 64'd0);
    beat_q.delete(); rd_q.delete(); done_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {gnt, beat_ack, done, rvalid, mem_en, mem_wr, mem_adr, mem_wdata, rdata}, 64'd0);
  endtask

  vec_t vecs [7];
  int st, s;

  initial begin
    vecs[0] = '{0, 1'b1, 16'h0100, 4,  16'h0103};
    vecs[1] = '{1, 1'b0, 16'h2000, 3,  16'h2002};
    vecs[2] = '{0, 1'b1, 16'hFFFE, 4,  16'h0001};
    vecs[3] = '{2, 1'b1, 16'h1234, 1,  16'h1234};
    vecs[4] = '{1, 1'b0, 16'hFFFF, 3,  16'h0001};
    vecs[5] = '{2, 1'b0, 16'h0040, 31, 16'h005E};
    vecs[6] = '{0, 1'b0, 16'h0100, 1,  16'h0100};
    for (int a = 0; a < 256; a++) golden[a] = pat(8'(a));
    for (int i = 0; i < 3; i++) issued[i] = 0;

    repeat (3) @(negedge clk);
    check_reset_outs("reset_outputs");

    // Contention: all three held from reset, two-beat writes, expected order 0,1,2,0.
    set_req(0, 1'b1, 16'h0310, 2);
    set_req(1, 1'b1, 16'h0420, 2);
    set_req(2, 1'b1, 16'h0530, 2);
    req = 3'b111;
    @(negedge clk);
    rst = 1'b1;
    st = cyc;
    s = push_burst(0, 1'b1, 16'h0310, 2, st, 99);
    s = push_burst(1, 1'b1, 16'h0420, 2, s, 99);
    s = push_burst(2, 1'b1, 16'h0530, 2, s, 99);
    s = push_burst(0, 1'b1, 16'h0310, 2, s, 99);
    wait_cyc(st + 4);  req[1] = 1'b0;
    wait_cyc(st + 7);  req[2] = 1'b0;
    wait_cyc(st + 10); req[0] = 1'b0;
    drain();

    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].o, vecs[i].w, vecs[i].b, vecs[i].l);
      req = 3'b001 << vecs[i].o;
      st = cyc;
      void'(push_burst(vecs[i].o, vecs[i].w, vecs[i].b, vecs[i].l, st, 99));
      @(negedge clk);
      req = 3'b000;
      drain();
      check($sformatf("end_adr_%0d", i), 64'(last_done_adr), 64'(vecs[i].end_adr));
    end

    // Null burst from requester 2, then requester 0 is served right behind it.
    set_req(2, 1'b0, 16'h0600, 0);
    set_req(0, 1'b1, 16'h0700, 1);
    req = 3'b101;
    st = cyc;
    s = push_burst(2, 1'b0, 16'h0600, 0, st, 99);
    s = push_burst(0, 1'b1, 16'h0700, 1, s, 99);
    wait_cyc(st + 1); req[2] = 1'b0;
    wait_cyc(st + 2); req[0] = 1'b0;
    drain();

    // Reset lands during the second beat of an eight-beat write.
    set_req(0, 1'b1, 16'h0500, 8);
    req = 3'b001;
    st = cyc;
    void'(push_burst(0, 1'b1, 16'h0500, 8, st, 1));
    wait_cyc(st + 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outs("reset_async");
    set_req(0, 1'b1, 16'h0310, 2);
    set_req(1, 1'b1, 16'h0420, 2);
    req = 3'b011;
    repeat (2) @(negedge clk);
    check_reset_outs("reset_hold");
    check("reset_no_done", 64'(beat_q.size() + done_q.size()), 64'd0);
    beat_q.delete(); done_q.delete(); rd_q.delete();
    for (int i = 0; i < 3; i++) issued[i] = 0;
    rst = 1'b1;
    st = cyc;
    s = push_burst(0, 1'b1, 16'h0310, 2, st, 99);
    s = push_burst(1, 1'b1, 16'h0420, 2, s, 99);
    wait_cyc(st + 1); req[0] = 1'b0;
    wait_cyc(st + 4); req[1] = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_mem_arbiter.md
Name: conv_mem_arbiter

Overview:
Burst-atomic round-robin arbiter that shares the accelerator's single-port data memory between three requesters: filter loader (0), image-slice loader (1) and result write-back (2). Each requester posts base address, length and direction. The arbiter owns the memory port for the whole burst, generates sequential addresses, steers write data and routes read data back. It sits between the convolution controller/datapath and the memory, replacing the controller's direct address-select muxing.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 8, memory data width
LEN_W, 5, burst length field width (1..2^LEN_W-1 beats; 0 is a null burst)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req  in  3  per-requester burst request, level
wr  in  3  per-requester direction, 1=write, 0=read
base  in  3*ADDR_W  per-requester start address, slice i at [i*ADDR_W +: ADDR_W]
len  in  3*LEN_W  per-requester beat count
wdata  in  3*DATA_W  per-requester write data
gnt  out  3  one-hot owner of memory port
beat_ack  out  3  pulse per issued beat to owner (write data consumed / address issued)
done  out  3  one-cycle pulse to owner when burst completes
rvalid  out  3  read data valid for owner
rdata  out  DATA_W  read data, equals mem_rdata
mem_en  out  1  memory access enable
mem_wr  out  1  memory write strobe
mem_adr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after read address

Behaviour:
- Registered state: state, owner (2b), last_owner (2b), cur_adr, beats_left, dir, rvalid.
- Outputs are Moore functions of registered state, except mem_wdata and rdata, which are combinational muxes.
- Reset (rst=0, async): state=IDLE, last_owner=2, all outputs 0, any in-flight burst discarded. No done is issued for it.
- States: IDLE, BURST, TAIL.
- IDLE:
  - If any req is set, pick the winner by searching last_owner+1, +2, +3 (mod 3).
  - Latch owner, base, len and wr, and set last_owner=winner.
  - len!=0: go to BURST.
  - len==0: stay in IDLE, pulse done[winner] next cycle. No memory access and no gnt.
  - If no req is set, hold.
- BURST, each cycle:
  - gnt[owner]=1, mem_en=1, mem_wr=dir, mem_adr=cur_adr, beat_ack[owner]=1.
  - mem_wdata=wdata[owner] for writes, 0 for reads.
  - cur_adr increments mod 2^ADDR_W (wraps FFFF->0000).
  - beats_left decrements.
  - On the last beat (beats_left==1), done[owner]=1 in the same cycle. Write bursts go to IDLE; read bursts go to TAIL.
- TAIL:
  - gnt[owner] stays 1, mem_en=0, rvalid[owner]=1 for the final read beat.
  - Then go to IDLE.
- Read timing: a read beat issued in cycle t produces rvalid[owner]=1 and rdata=mem_rdata in t+1. rvalid is high continuously for back-to-back beats.
- Latency:
  - req seen in IDLE at cycle t gives the first mem_en at t+1.
  - After a write burst's last beat at t, the next grant's first beat is at t+2.
  - After a read burst, the next grant's first beat is at t+3.
- Requester rules:
  - base, len and wr are sampled only in the winning IDLE cycle. Later changes do not affect the burst.
  - Dropping req mid-burst is ignored and the burst completes.
  - Holding req after done produces a new burst under round-robin.
- New requests arriving during BURST/TAIL wait and are never lost while req is held.
- gnt is one-hot or zero; done, beat_ack and rvalid only ever target the current owner.
- Starvation bound: a held request is granted within 2 other bursts.

Test Plan:
- Single write: req=001, wr0=1, base0=0x0100, len0=4, wdata0 stepping 0xA0..0xA3 -> mem_en high 4 cycles starting 1 cycle after req, adr 0x0100..0x0103, data A0..A3, done[0] on 4th beat, gnt 001 throughout.
- Single read: req=010, wr1=0, base1=0x2000, len1=3, memory preloaded 11,22,33 -> rvalid[1] for 3 consecutive cycles, each 1 cycle after its address, rdata 11,22,33. done[1] on 3rd address, TAIL cycle present, gnt 010 for 4 cycles.
- Contention: all three req held from reset, each len=2 writes -> grant order 0,1,2,0. Exactly one idle cycle between bursts; gnt never multi-hot.
- Null burst: req=100, len2=0 -> no mem_en, no gnt, done[2] pulses once; next requester served next.
- Wrap: base0=0xFFFE, len0=4 -> addresses FFFE, FFFF, 0000, 0001.
- Reset mid-burst: assert rst=0 on 2nd beat of a len=8 write -> all outputs 0 immediately (async), no done. After release with req0 and req1 both held, requester 0 wins first (last_owner=2).
